// File: rtl/core_seq_ctrl_if.sv
// Job-control and buffer-read bundle between a job issuer and the per-core read sequencer.
// The master issues jobs and reports buffer status; the slave drives the read strobes.
interface core_seq_ctrl_if #(
    parameter int CDATA_BIT = 8,
    parameter int OUT_BIT   = 8
);
    logic                 start;
    logic [CDATA_BIT-1:0] cfg_acc_num;
    logic [OUT_BIT-1:0]   cfg_out_num;
    logic                 lbuf_empty;
    logic                 abuf_empty;
    logic                 abuf_reuse_empty;
    logic                 lbuf_ren;
    logic                 abuf_ren;
    logic                 abuf_reuse_ren;
    logic                 abuf_reuse_rst;
    logic                 busy;
    logic                 done;
    logic [CDATA_BIT-1:0] word_cnt;
    logic [OUT_BIT-1:0]   out_cnt;

    modport master (
        output start, cfg_acc_num, cfg_out_num,
        output lbuf_empty, abuf_empty, abuf_reuse_empty,
        input  lbuf_ren, abuf_ren, abuf_reuse_ren, abuf_reuse_rst,
        input  busy, done, word_cnt, out_cnt
    );

    modport slave (
        input  start, cfg_acc_num, cfg_out_num,
        input  lbuf_empty, abuf_empty, abuf_reuse_empty,
        output lbuf_ren, abuf_ren, abuf_reuse_ren, abuf_reuse_rst,
        output busy, done, word_cnt, out_cnt
    );
endinterface

// File: rtl/core_seq_ctrl.sv
// Per-core read sequencer: streams out_num rows of acc_num weight/activation reads,
// replaying activations through the reuse path after row 0, then drains and pulses done.
module core_seq_ctrl #(
    parameter int CDATA_BIT = 8,
    parameter int OUT_BIT   = 8,
    parameter int DRAIN_CYC = 8
) (
    input  logic          clk,
    input  logic          rst,
    core_seq_ctrl_if.slave bus
);
    localparam int DW = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC) : 1;

    typedef enum logic [2:0] {IDLE, RUN, REWIND, DRAIN, DONE} state_t;

    state_t               state;
    logic [CDATA_BIT-1:0] word_cnt;
    logic [OUT_BIT-1:0]   out_cnt;
    logic [DW-1:0]        drain_cnt;
    logic [CDATA_BIT-1:0] acc_num_q;
    logic [OUT_BIT-1:0]   out_num_q;
    logic                 busy_q;
    logic                 done_q;
    logic                 reuse_rst_q;

    logic avail;
    logic issue;
    logic row_last;
    logic job_last;
    logic first_row;

    assign first_row = (out_cnt == '0);
    assign avail     = !bus.lbuf_empty &&
                       (first_row ? !bus.abuf_empty : !bus.abuf_reuse_empty);
    assign issue     = (state == RUN) && avail;
    assign row_last  = (word_cnt == acc_num_q - CDATA_BIT'(1));
    assign job_last  = ((out_cnt + OUT_BIT'(1)) == out_num_q);

    // Strobes are combinational so a read lands in the same cycle the source is seen non-empty.
    assign bus.lbuf_ren       = issue;
    assign bus.abuf_ren       = issue && first_row;
    assign bus.abuf_reuse_ren = issue && !first_row;
    assign bus.abuf_reuse_rst = reuse_rst_q;
    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.word_cnt       = word_cnt;
    assign bus.out_cnt        = out_cnt;

    // Job configuration is captured only on an accepted start.
    always_ff @(posedge clk) begin
        if (state == IDLE && bus.start) begin
            acc_num_q <= bus.cfg_acc_num;
            out_num_q <= bus.cfg_out_num;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            word_cnt    <= '0;
            out_cnt     <= '0;
            drain_cnt   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            reuse_rst_q <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            reuse_rst_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        word_cnt <= '0;
                        out_cnt  <= '0;
                        if (bus.cfg_acc_num != '0 && bus.cfg_out_num != '0) begin
                            state  <= RUN;
                            busy_q <= 1'b1;
                        end else begin
                            state  <= DONE;
                            done_q <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    if (issue) begin
                        if (row_last) begin
                            word_cnt <= '0;
                            out_cnt  <= out_cnt + OUT_BIT'(1);
                            if (job_last) begin
                                state     <= DRAIN;
                                drain_cnt <= '0;
                            end else begin
                                state       <= REWIND;
                                reuse_rst_q <= 1'b1;
                            end
                        end else begin
                            word_cnt <= word_cnt + CDATA_BIT'(1);
                        end
                    end
                end
                REWIND: begin
                    state <= RUN;
                end
                DRAIN: begin
                    if (drain_cnt == DW'(DRAIN_CYC - 1)) begin
                        state  <= DONE;
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                    end else begin
                        drain_cnt <= drain_cnt + DW'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state  <= IDLE;
                    busy_q <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_core_seq_ctrl.sv
// Scoreboard bench for core_seq_ctrl: jobs push their expected strobe/rewind/done events,
// a monitor pops and compares whenever the sequencer presents one.
module tb_core_seq_ctrl;
    localparam int CB = 8;
    localparam int OB = 8;
    localparam int D  = 8;

    localparam int K_FRESH = 0;
    localparam int K_REUSE = 1;
    localparam int K_RST   = 2;
    localparam int K_DONE  = 3;

    typedef struct {
        int kind;
        int word;
        int outc;
        int cyc;
    } ev_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    core_seq_ctrl_if #(.CDATA_BIT(CB), .OUT_BIT(OB)) bus ();

    core_seq_ctrl #(.CDATA_BIT(CB), .OUT_BIT(OB), .DRAIN_CYC(D)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    ev_t q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;
    int  n_l, n_a, n_r, n_rst, n_done;
    bit  busy_seen;
    bit  stall_mode = 1'b0;

    task automatic check(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
    end

    // Monitor: invariants on every strobe cycle, scoreboard pop on every event.
    initial forever begin
        int  k;
        ev_t e;
        @(negedge clk);
        if (!rst) begin
            if (bus.busy) busy_seen = 1'b1;
            if (bus.lbuf_ren || bus.abuf_ren || bus.abuf_reuse_ren) begin
                check("lbuf_ren_pairs_one_abuf", int'(bus.lbuf_ren),
                      int'(bus.abuf_ren ^ bus.abuf_reuse_ren));
                check("ren_while_empty",
                      int'((bus.lbuf_ren && bus.lbuf_empty) ||
                           (bus.abuf_ren && bus.abuf_empty) ||
                           (bus.abuf_reuse_ren && bus.abuf_reuse_empty)), 0);
            end
            n_l    += int'(bus.lbuf_ren);
            n_a    += int'(bus.abuf_ren);
            n_r    += int'(bus.abuf_reuse_ren);
            n_rst  += int'(bus.abuf_reuse_rst);
            n_done += int'(bus.done);
            k = -1;
            if (bus.abuf_ren)            k = K_FRESH;
            else if (bus.abuf_reuse_ren) k = K_REUSE;
            else if (bus.abuf_reuse_rst) k = K_RST;
            else if (bus.done)           k = K_DONE;
            if (k >= 0) begin
                if (q.size() == 0) begin
                    check("unexpected_event_kind", k, -1);
                end else begin
                    e = q.pop_front();
                    check("event_kind", k, e.kind);
                    if (e.word >= 0) check("event_word_cnt", int'(bus.word_cnt), e.word);
                    if (e.outc >= 0) check("event_out_cnt", int'(bus.out_cnt), e.outc);
                    if (e.cyc >= 0)  check("event_cycle", cyc, e.cyc);
                end
            end
        end
    end

    // Stall driver: lbuf toggles each cycle; reuse path goes empty for 5 cycles once row 1 starts.
    initial begin
        int rh_left = 0;
        bit rh_done = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode) begin
                bus.lbuf_empty = ~bus.lbuf_empty;
                if (!rh_done && bus.busy && bus.out_cnt == OB'(1)) begin
                    rh_done = 1'b1;
                    rh_left = 5;
                end
                if (rh_left > 0) begin
                    bus.abuf_reuse_empty = 1'b1;
                    rh_left--;
                end else begin
                    bus.abuf_reuse_empty = 1'b0;
                end
            end
        end
    end

    task automatic clr_counts();
        n_l = 0; n_a = 0; n_r = 0; n_rst = 0; n_done = 0;
        busy_seen = 1'b0;
    endtask

    // Expected event stream of a job; cycle numbers only when no stalls are applied.
    task automatic push_job(input int acc, input int outn, input int st, input bit chk);
        int t;
        t = st + 1;
        if (acc == 0 || outn == 0) begin
            q.push_back('{K_DONE, -1, -1, chk ? st + 1 : -1});
            return;
        end
        for (int r = 0; r < outn; r++) begin
            for (int w = 0; w < acc; w++) begin
                q.push_back('{(r == 0) ? K_FRESH : K_REUSE, w, r, chk ? t : -1});
                t++;
            end
            if (r < outn - 1) begin
                q.push_back('{K_RST, 0, r + 1, chk ? t : -1});
                t++;
            end
        end
        q.push_back('{K_DONE, -1, -1, chk ? t + D : -1});
    endtask

    task automatic start_job(input int acc, input int outn, input bit chk);
        @(posedge clk);
        #1;
        clr_counts();
        bus.cfg_acc_num = CB'(acc);
        bus.cfg_out_num = OB'(outn);
        push_job(acc, outn, cyc, chk);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while (q.size() != 0 && n < budget) begin
            @(negedge clk);
            #1;
            n++;
        end
        check(name, q.size(), 0);
        repeat (4) @(negedge clk);
        #1;
        check({name, "_busy_after"}, int'(bus.busy), 0);
    endtask

    task automatic check_totals(input string name, input int acc, input int outn);
        int on;
        on = (acc == 0) ? 0 : outn;
        check({name, "_lbuf_ren"}, n_l, acc * on);
        check({name, "_abuf_ren"}, n_a, (on == 0) ? 0 : acc);
        check({name, "_reuse_ren"}, n_r, (on == 0) ? 0 : acc * (on - 1));
        check({name, "_reuse_rst"}, n_rst, (on == 0) ? 0 : on - 1);
        check({name, "_done"}, n_done, 1);
    endtask

    initial begin
        bit found;
        bus.start            = 1'b0;
        bus.cfg_acc_num      = '0;
        bus.cfg_out_num      = '0;
        bus.lbuf_empty       = 1'b0;
        bus.abuf_empty       = 1'b0;
        bus.abuf_reuse_empty = 1'b0;
        clr_counts();

        #12;
        check("rst_busy", int'(bus.busy), 0);
        check("rst_done", int'(bus.done), 0);
        check("rst_word_cnt", int'(bus.word_cnt), 0);
        check("rst_out_cnt", int'(bus.out_cnt), 0);
        check("rst_ren", int'(bus.lbuf_ren | bus.abuf_ren | bus.abuf_reuse_ren), 0);
        check("rst_reuse_rst", int'(bus.abuf_reuse_rst), 0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Single row, buffers always available.
        start_job(4, 1, 1'b1);
        wait_idle("job_4x1", 200);
        check_totals("job_4x1", 4, 1);

        // Three rows with rewinds between them.
        start_job(3, 3, 1'b1);
        wait_idle("job_3x3", 200);
        check_totals("job_3x3", 3, 3);

        // Stalls on both weight and reuse sources.
        stall_mode = 1'b1;
        start_job(4, 2, 1'b0);
        wait_idle("job_4x2_stall", 400);
        check_totals("job_4x2_stall", 4, 2);
        stall_mode = 1'b0;
        @(posedge clk);
        #2;
        bus.lbuf_empty       = 1'b0;
        bus.abuf_reuse_empty = 1'b0;

        // Degenerate configurations finish without reads.
        start_job(4, 0, 1'b1);
        wait_idle("job_out0", 50);
        check_totals("job_out0", 4, 0);
        check("job_out0_busy_seen", int'(busy_seen), 0);
        start_job(0, 3, 1'b1);
        wait_idle("job_acc0", 50);
        check_totals("job_acc0", 0, 3);
        check("job_acc0_busy_seen", int'(busy_seen), 0);

        // Asynchronous abort mid-row.
        start_job(4, 3, 1'b1);
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #1;
            if (bus.out_cnt == OB'(1) && bus.word_cnt == CB'(2)) found = 1'b1;
        end
        check("abort_reached_mid_row", int'(found), 1);
        #1;
        rst = 1'b1;
        #1;
        check("abort_ren", int'(bus.lbuf_ren | bus.abuf_ren | bus.abuf_reuse_ren), 0);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_word_cnt", int'(bus.word_cnt), 0);
        check("abort_out_cnt", int'(bus.out_cnt), 0);
        check("abort_done", int'(bus.done), 0);
        q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        start_job(2, 2, 1'b1);
        wait_idle("job_after_abort", 200);
        check_totals("job_after_abort", 2, 2);

        // Restarts during RUN and during DONE, with cfg inputs changed mid-job.
        start_job(3, 2, 1'b1);
        bus.start       = 1'b1;
        bus.cfg_acc_num = CB'(5);
        bus.cfg_out_num = OB'(4);
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 100 && !found; i++) begin
            @(negedge clk);
            #1;
            if (bus.done) found = 1'b1;
        end
        check("restart_done_seen", int'(found), 1);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        wait_idle("job_restart", 50);
        repeat (10) @(negedge clk);
        check_totals("job_restart", 3, 2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout want finish");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/core_seq_ctrl.md
Name: core_seq_ctrl

Overview:
- Per-core read sequencer that sits directly upstream of the core datapath. It drives the weight buffer (lbuf) and activation buffer (abuf) read strobes that feed the MAC/ACC/quant chain.
- For one matrix-vector job it streams cfg_out_num output rows of cfg_acc_num words each. Row 0 reads fresh activations; later rows replay them through the abuf reuse path.
- After the last read it waits out the datapath latency, then pulses done.

Parameters:
- CDATA_BIT, 8, width of cfg_acc_num and word counter
- OUT_BIT, 8, width of cfg_out_num and row counter
- DRAIN_CYC, 8, cycles from last issued read until done (datapath latency margin), >=1

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous active-high reset
- start  input  1  single-cycle job start pulse
- cfg_acc_num  input  CDATA_BIT  words per output row
- cfg_out_num  input  OUT_BIT  output rows per job
- lbuf_empty  input  1  weight buffer empty
- abuf_empty  input  1  activation buffer empty
- abuf_reuse_empty  input  1  activation reuse path empty
- lbuf_ren  output  1  weight read strobe
- abuf_ren  output  1  fresh activation read strobe
- abuf_reuse_ren  output  1  activation reuse read strobe
- abuf_reuse_rst  output  1  rewind reuse pointer, one-cycle pulse
- busy  output  1  job in progress (RUN, REWIND or DRAIN)
- done  output  1  one-cycle job-complete pulse
- word_cnt  output  CDATA_BIT  words issued in current row
- out_cnt  output  OUT_BIT  rows completed

Behaviour:
- Reset (async, rst=1): state=IDLE. All counters are 0; busy, done and abuf_reuse_rst are 0; all ren are 0. Reset mid-job aborts immediately with no done.
- cfg_acc_num and cfg_out_num are latched on the accepted start. Later changes to the cfg inputs do not affect a running job.
- States: IDLE, RUN, REWIND, DRAIN, DONE.
- IDLE:
  - start=1 with both cfg values nonzero -> RUN; counters cleared.
  - start=1 with either cfg value zero -> DONE directly; no reads are issued.
- start while not IDLE is ignored.
- RUN, issue condition:
  - avail = !lbuf_empty && (out_cnt==0 ? !abuf_empty : !abuf_reuse_empty).
  - Strobes are combinational in the same cycle: lbuf_ren = RUN && avail.
  - abuf_ren = RUN && avail && out_cnt==0.
  - abuf_reuse_ren = RUN && avail && out_cnt!=0.
  - At most one of abuf_ren / abuf_reuse_ren is ever high. Strobes never assert while the selected source is empty.
- RUN, counting (per issued read):
  - word_cnt increments.
  - When word_cnt reaches latched acc_num-1 on an issued read, word_cnt wraps to 0 and out_cnt increments.
  - Then, if out_cnt+1 == out_num -> DRAIN. Otherwise -> REWIND.
- RUN, stalls: no issue -> hold all state; no bubbles are counted.
- REWIND:
  - One cycle, abuf_reuse_rst=1, no ren; then back to RUN.
  - It occurs between every pair of rows, including row 0 -> row 1.
- DRAIN: a counter counts DRAIN_CYC cycles with no strobes; then -> DONE.
- DONE: done=1 for exactly one cycle; busy=0; -> IDLE. A start in this cycle is ignored.
- busy=1 in RUN, REWIND and DRAIN.
- Counter widths:
  - word_cnt and out_cnt never exceed their latched limits.
  - acc_num=1 is legal: every issued read completes a row.
  - Maximum acc_num=2^CDATA_BIT-1 requires no extra bit.
- Issue count per job: total strobes = acc_num*out_num. abuf_ren count = acc_num. abuf_reuse_ren count = acc_num*(out_num-1). abuf_reuse_rst pulses = out_num-1.

Test Plan:
- acc_num=4, out_num=1, buffers never empty -> 4 consecutive lbuf_ren+abuf_ren cycles, no reuse_rst. done pulses 1+4+DRAIN_CYC cycles after start (fixed cycle number asserted).
- acc_num=3, out_num=3, always available -> pattern 3 fresh reads, reuse_rst, 3 reuse reads, reuse_rst, 3 reuse reads. Totals: 9 lbuf_ren, 3 abuf_ren, 6 abuf_reuse_ren, 2 reuse_rst; single done.
- acc_num=4, out_num=2, lbuf_empty toggling every other cycle and abuf_reuse_empty high for 5 cycles in row 1 -> no strobe while the selected source is empty. Counts unchanged vs. no-stall case; word_cnt holds during stalls.
- cfg_out_num=0 with start -> done exactly one cycle later, zero strobes, busy never high. Repeat the same with cfg_acc_num=0.
- rst asserted mid-row (word_cnt=2, out_cnt=1) -> strobes, busy and counters go 0 asynchronously; no done. A new start afterwards runs a full job correctly.
- start re-pulsed during RUN and during the DONE cycle, with cfg inputs changed mid-job -> both pulses ignored; job completes using the originally latched values.
